// File: rtl/sd_block_reader.sv
// Reads one SD data block: waits for the 0xFE start token, streams BLOCK_BYTES data
// bytes with their index, then checks the trailing CRC16-CCITT (poly 0x1021, init 0).
module sd_block_reader #(
   parameter int BLOCK_BYTES   = 512,
   parameter int TOKEN_TIMEOUT = 255
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] byteIn,
   input  logic       byteDone,
   output logic       rxEnable,
   output logic [7:0] dataOut,
   output logic       dataValid,
   output logic [8:0] byteIndex,
   output logic       busy,
   output logic       blockDone,
   output logic       crcError,
   output logic       timeout,
   output logic       tokenError
);

   localparam int TW = (TOKEN_TIMEOUT > 2) ? $clog2(TOKEN_TIMEOUT) : 1;
   localparam logic [TW-1:0] TOK_LAST = TW'(TOKEN_TIMEOUT - 1);
   localparam logic [8:0]    IDX_LAST = 9'(BLOCK_BYTES - 1);

   typedef enum logic [2:0] {
      IDLE, TOK_REQ, TOK_WAIT, DAT_REQ, DAT_WAIT, CRC_REQ, CRC_WAIT, DONE
   } state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [TW-1:0]   r_tok_cnt;
   logic [8:0]      r_byte_cnt;
   logic [15:0]     r_crc;
   logic [7:0]      r_crc_hi;
   logic            r_crc_second;
   logic [7:0]      r_data_out;
   logic            r_data_valid;
   logic [8:0]      r_byte_index;
   logic            r_crc_error;
   logic            r_timeout;
   logic            r_token_error;
   logic [15:0]     w_crc_next;

   // Bit-serial CRC update, MSB of the byte first.
   function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
      logic [15:0] c;
      c = crc;
      for (int k = 7; k >= 0; k--) begin
         c = {c[14:0], 1'b0} ^ ((c[15] ^ d[k]) ? 16'h1021 : 16'h0000);
      end
      return c;
   endfunction

   assign w_crc_next = crc16_byte(r_crc, byteIn);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      rxEnable     = 1'b0;
      busy         = 1'b1;
      blockDone    = 1'b0;
      unique case (r_state)
         IDLE: begin
            busy = 1'b0;
            if (start) w_state_next = TOK_REQ;
         end
         TOK_REQ: begin
            rxEnable     = 1'b1;
            w_state_next = TOK_WAIT;
         end
         TOK_WAIT: begin
            if (byteDone) begin
               if (byteIn == 8'hFE)            w_state_next = DAT_REQ;
               else if (byteIn[7:5] == 3'b000) w_state_next = DONE;
               else if (r_tok_cnt == TOK_LAST) w_state_next = DONE;
               else                            w_state_next = TOK_REQ;
            end
         end
         DAT_REQ: begin
            rxEnable     = 1'b1;
            w_state_next = DAT_WAIT;
         end
         DAT_WAIT: begin
            if (byteDone) w_state_next = (r_byte_cnt == IDX_LAST) ? CRC_REQ : DAT_REQ;
         end
         CRC_REQ: begin
            rxEnable     = 1'b1;
            w_state_next = CRC_WAIT;
         end
         CRC_WAIT: begin
            if (byteDone) w_state_next = r_crc_second ? DONE : CRC_REQ;
         end
         DONE: begin
            blockDone    = 1'b1;
            w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_tok_cnt     <= '0;
         r_byte_cnt    <= '0;
         r_crc         <= '0;
         r_crc_hi      <= '0;
         r_crc_second  <= 1'b0;
         r_data_out    <= '0;
         r_data_valid  <= 1'b0;
         r_byte_index  <= '0;
         r_crc_error   <= 1'b0;
         r_timeout     <= 1'b0;
         r_token_error <= 1'b0;
      end else begin
         r_data_valid <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  r_tok_cnt     <= '0;
                  r_byte_cnt    <= '0;
                  r_crc         <= '0;
                  r_crc_second  <= 1'b0;
                  r_crc_error   <= 1'b0;
                  r_timeout     <= 1'b0;
                  r_token_error <= 1'b0;
               end
            end
            TOK_WAIT: begin
               if (byteDone && byteIn != 8'hFE) begin
                  if (byteIn[7:5] == 3'b000)      r_token_error <= 1'b1;
                  else if (r_tok_cnt == TOK_LAST) r_timeout     <= 1'b1;
                  else                            r_tok_cnt     <= r_tok_cnt + TW'(1);
               end
            end
            DAT_WAIT: begin
               if (byteDone) begin
                  r_data_out   <= byteIn;
                  r_data_valid <= 1'b1;
                  r_byte_index <= r_byte_cnt;
                  r_crc        <= w_crc_next;
                  if (r_byte_cnt != IDX_LAST) r_byte_cnt <= r_byte_cnt + 9'd1;
               end
            end
            CRC_WAIT: begin
               // Received CRC arrives high byte first.
               if (byteDone) begin
                  if (!r_crc_second) begin
                     r_crc_hi     <= byteIn;
                     r_crc_second <= 1'b1;
                  end else begin
                     r_crc_error  <= ({r_crc_hi, byteIn} != r_crc);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign dataOut    = r_data_out;
   assign dataValid  = r_data_valid;
   assign byteIndex  = r_byte_index;
   assign crcError   = r_crc_error;
   assign timeout    = r_timeout;
   assign tokenError = r_token_error;

endmodule

// File: tb/tb_sd_block_reader.sv
// Directed bench for sd_block_reader: a byte-receiver model feeds queued bytes on
// rxEnable, and a scoreboard of expected {byteIndex,dataOut} is checked on dataValid.
module tb_sd_block_reader;

   localparam int BB = 512;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] byteIn;
   logic       byteDone;
   logic       rxEnable;
   logic [7:0] dataOut;
   logic       dataValid;
   logic [8:0] byteIndex;
   logic       busy;
   logic       blockDone;
   logic       crcError;
   logic       timeout;
   logic       tokenError;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [7:0]  byte_feed[$];
   logic [16:0] exp_data[$];
   logic        exp_crc, exp_to, exp_tok;
   int          first_dv, last_dv;

   sd_block_reader #(.BLOCK_BYTES(BB), .TOKEN_TIMEOUT(255)) dut (
      .clock(clock), .reset(reset), .start(start), .byteIn(byteIn), .byteDone(byteDone),
      .rxEnable(rxEnable), .dataOut(dataOut), .dataValid(dataValid), .byteIndex(byteIndex),
      .busy(busy), .blockDone(blockDone), .crcError(crcError), .timeout(timeout),
      .tokenError(tokenError)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests_run++;
      assert (obs === expv) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " ctl"}, 32'({rxEnable, dataValid, busy, blockDone, crcError, timeout, tokenError}), 32'd0);
      check({tag, " dataOut"}, 32'(dataOut), 32'd0);
      check({tag, " byteIndex"}, 32'(byteIndex), 32'd0);
   endtask

   // Reference CRC16-CCITT, byte-wise shift-register form.
   function automatic logic [15:0] crc_upd(input logic [15:0] c_in, input logic [7:0] d);
      logic [15:0] c;
      c = c_in ^ {d, 8'h00};
      for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
      return c;
   endfunction

   // pattern 0: zeros, 1: i mod 256, 2: random
   task automatic feed_block(input int pattern, input bit flip);
      logic [15:0] c;
      logic [7:0]  d;
      c = 16'h0000;
      byte_feed.push_back(8'hFE);
      for (int i = 0; i < BB; i++) begin
         d = (pattern == 0) ? 8'h00 : (pattern == 1) ? 8'(i) : 8'($urandom_range(0, 255));
         byte_feed.push_back(d);
         exp_data.push_back({9'(i), d});
         c = crc_upd(c, d);
      end
      byte_feed.push_back(c[15:8]);
      byte_feed.push_back(flip ? (c[7:0] ^ 8'h01) : c[7:0]);
      exp_crc = flip; exp_to = 1'b0; exp_tok = 1'b0;
   endtask

   // Caller raises start at a negedge just before calling. abort_idx >= 0 asserts reset
   // when that byteIndex is seen; inject exercises start-while-busy, byteDone in a REQ
   // state and start coincident with blockDone.
   task automatic run_block(input int abort_idx, input bit inject);
      bit          pending = 0, done = 0, inj_bd = 0, inj_st = 0;
      int          cyc = 0;
      logic [16:0] e;
      first_dv = -1; last_dv = -1;
      while (!done && cyc < 3000) begin
         @(negedge clock);
         cyc++;
         byteDone = 1'b0;
         start    = 1'b0;
         if (dataValid) begin
            if (exp_data.size() == 0) check("unexpected dataValid", 32'd1, 32'd0);
            else begin
               e = exp_data.pop_front();
               check("byteIndex", 32'(byteIndex), 32'(e[16:8]));
               check("dataOut", 32'(dataOut), 32'(e[7:0]));
               $display("[TB] byte idx=%0d data=%02h", byteIndex, dataOut);
            end
            if (first_dv < 0) first_dv = cyc;
            last_dv = cyc;
            if (inject && !inj_st && byteIndex == 9'd10) begin
               start = 1'b1; inj_st = 1;
            end
            if (abort_idx >= 0 && int'(byteIndex) == abort_idx) begin
               reset = 1'b1;
               break;
            end
         end
         if (blockDone) begin
            check("crcError", 32'(crcError), 32'(exp_crc));
            check("timeout", 32'(timeout), 32'(exp_to));
            check("tokenError", 32'(tokenError), 32'(exp_tok));
            check("missing dataValid count", 32'(exp_data.size()), 32'd0);
            check("unconsumed feed bytes", 32'(byte_feed.size()), 32'd0);
            $display("[TB] blockDone crc=%0b to=%0b tok=%0b", crcError, timeout, tokenError);
            done = 1;
            if (inject) start = 1'b1;
         end else if (pending) begin
            pending = 0;
            if (byte_feed.size() == 0) begin
               check("feed underrun", 32'd1, 32'd0);
               break;
            end
            byteIn   = byte_feed.pop_front();
            byteDone = 1'b1;
         end else if (rxEnable) begin
            pending = 1;
            if (inject && !inj_bd && byteIndex >= 9'd20) begin
               byteIn = 8'hAA; byteDone = 1'b1; inj_bd = 1;
            end
         end
      end
      if (abort_idx < 0) check("blockDone reached", 32'(done), 32'd1);
      if (inject && done) begin
         @(negedge clock);
         start = 1'b0;
         check("start at blockDone ignored", 32'(busy), 32'd0);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; byteIn = 8'h00; byteDone = 1'b0;
      repeat (2) @(negedge clock);
      check_reset_outputs("reset");
      reset = 1'b0;
      @(negedge clock);
      check_reset_outputs("after reset");

      // Two idle bytes, token, zero data, CRC 0x0000; with ignored start/byteDone.
      byte_feed.push_back(8'hFF); byte_feed.push_back(8'hFF);
      feed_block(0, 1'b0);
      @(negedge clock); start = 1'b1;
      run_block(-1, 1'b1);

      // Counting pattern with correct CRC; also checks sustained rate.
      feed_block(1, 1'b0);
      @(negedge clock); start = 1'b1;
      run_block(-1, 1'b0);
      check("throughput", 32'((last_dv - first_dv) <= 3 * (BB - 1)), 32'd1);

      // Same pattern with low CRC byte flipped; flag must hold afterwards.
      feed_block(1, 1'b1);
      @(negedge clock); start = 1'b1;
      run_block(-1, 1'b0);
      @(negedge clock);
      check("crcError held", 32'({busy, crcError}), 32'b01);

      // 255 non-token bytes -> timeout.
      for (int i = 0; i < 255; i++) byte_feed.push_back(8'hFF);
      exp_crc = 1'b0; exp_to = 1'b1; exp_tok = 1'b0;
      @(negedge clock); start = 1'b1;
      run_block(-1, 1'b0);

      // Data-error token -> tokenError.
      byte_feed.push_back(8'hFF); byte_feed.push_back(8'h05);
      exp_crc = 1'b0; exp_to = 1'b0; exp_tok = 1'b1;
      @(negedge clock); start = 1'b1;
      run_block(-1, 1'b0);

      // Reset mid-block at byteIndex 100, then a fresh random block from index 0.
      feed_block(2, 1'b0);
      @(negedge clock); start = 1'b1;
      run_block(100, 1'b0);
      #1;
      check_reset_outputs("mid-block reset");
      byteDone = 1'b0;
      byte_feed.delete();
      exp_data.delete();
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check_reset_outputs("after mid-block reset");
      feed_block(2, 1'b0);
      @(negedge clock); start = 1'b1;
      run_block(-1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/sd_block_reader.md
SD_BLOCK_READER -- requirements
Module: sd_block_reader

Interface
REQ-001 SHALL have parameter BLOCK_BYTES, default 512, number of data bytes per block.
REQ-002 SHALL have parameter TOKEN_TIMEOUT, default 255, maximum non-token bytes accepted before the start token.
REQ-003 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to read one block; ignored unless idle.
REQ-006 SHALL have port byteIn  input  8  byte from the upstream serial byte receiver.
REQ-007 SHALL have port byteDone  input  1  one-cycle pulse; byteIn is valid in that cycle.
REQ-008 SHALL have port rxEnable  output  1  one-cycle pulse requesting the receiver to capture one byte.
REQ-009 SHALL have port dataOut  output  8  current data byte.
REQ-010 SHALL have port dataValid  output  1  one-cycle pulse; dataOut and byteIndex are valid.
REQ-011 SHALL have port byteIndex  output  9  index of dataOut within the block, 0..BLOCK_BYTES-1.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port blockDone  output  1  one-cycle pulse at block end; crcError, timeout and tokenError valid in that cycle.
REQ-014 SHALL have port crcError  output  1  CRC mismatch flag; held until next start.
REQ-015 SHALL have port timeout  output  1  no start token within TOKEN_TIMEOUT bytes; held until next start.
REQ-016 SHALL have port tokenError  output  1  data-error token received; held until next start.

Function
REQ-017 SHALL implement states IDLE, TOK_REQ, TOK_WAIT, DAT_REQ, DAT_WAIT, CRC_REQ, CRC_WAIT, DONE.
REQ-018 IDLE: start -> TOK_REQ; clear crcError, timeout, tokenError, token counter, byte counter, CRC register.
REQ-019 Each *_REQ state SHALL assert rxEnable for exactly one cycle and then move to its *_WAIT state.
REQ-020 A *_WAIT state SHALL hold, with rxEnable low, until byteDone; byteDone in any other state SHALL be ignored.
REQ-021 TOK_WAIT, byteIn = 0xFE: -> DAT_REQ.
REQ-022 TOK_WAIT, byteIn[7:5] = 000: set tokenError -> DONE.
REQ-023 TOK_WAIT, any other byte, counter < TOKEN_TIMEOUT-1: increment counter -> TOK_REQ.
REQ-024 TOK_WAIT, any other byte, counter = TOKEN_TIMEOUT-1: set timeout -> DONE.
REQ-025 DAT_WAIT on byteDone: register dataOut = byteIn; pulse dataValid the next cycle with byteIndex = counter; update the CRC.
REQ-026 DAT_WAIT counter handling: byteIndex = BLOCK_BYTES-1 -> CRC_REQ; else increment -> DAT_REQ.
REQ-027 CRC SHALL be CRC16-CCITT, polynomial 0x1021, init 0x0000, MSB first, computed over data bytes only, one byte per update.
REQ-028 Received CRC SHALL arrive high byte first, then low byte, via two CRC_REQ/CRC_WAIT passes.
REQ-029 On the second CRC byte, crcError SHALL be set if the 16-bit received value differs from the computed CRC -> DONE.
REQ-030 DONE SHALL pulse blockDone for one cycle -> IDLE.
REQ-031 Throughput: with byteDone arriving 1 cycle after rxEnable, SHALL sustain one byte per 3 cycles; no bytes dropped.
REQ-032 start while busy SHALL be ignored; start and blockDone in the same cycle -> start ignored.

Reset
REQ-033 Reset SHALL force IDLE immediately, including mid-block, and abandon any partial block with no blockDone.
REQ-034 Reset values: rxEnable, dataValid, busy, blockDone, crcError, timeout, tokenError = 0; dataOut = 0x00; byteIndex = 0; all counters and CRC = 0.

Verification
REQ-035 Feed 0xFF,0xFF,0xFE, 512 bytes of 0x00, CRC 0x0000 -> 512 dataValid pulses, byteIndex 0..511, blockDone, crcError = 0.
REQ-036 Feed 0xFE, bytes i mod 256, correct CRC -> crcError = 0; repeat with low CRC byte flipped -> crcError = 1 at blockDone.
REQ-037 Feed 255 bytes of 0xFF -> timeout = 1, blockDone after 255th byteDone, no dataValid.
REQ-038 Feed 0xFF then 0x05 -> tokenError = 1, blockDone, no dataValid.
REQ-039 Assert reset at byteIndex 100, then start -> outputs at reset values; new block restarts at byteIndex 0.
REQ-040 Pulse start while busy and byteDone while in a *_REQ state -> both ignored; byte count unchanged.
